// File: rtl/conv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// conv_arbiter_pkg
//   Shared types for the convolution datapath and the ConvOperator arbiter.
//   - WIDTH / LEN   : element width and vector length of one dot product
//   - data_vector   : LEN signed elements, element 0 in the low bits
//   - result_t      : signed dot-product result, wide enough for LEN products
//   - arb_state_t   : transaction phases of conv_arbiter
// -----------------------------------------------------------------------------
package conv_arbiter_pkg;

    localparam int WIDTH    = 8;
    localparam int LEN      = 4;
    localparam int RESULT_W = 2 * WIDTH + $clog2(LEN);

    typedef logic signed [WIDTH-1:0]    elem_t;
    typedef elem_t [LEN-1:0]            data_vector;
    typedef logic signed [RESULT_W-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/conv_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker.
//   Ports:
//     req  in  N    request bits
//     ptr  in  IW   index served last; search starts at ptr+1
//     any  out 1    at least one request present
//     idx  out IW   first requesting index after ptr (modulo N)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the farthest candidate to the nearest one; the last hit wins,
    // so the nearest requester after ptr takes priority without a break.
    always_comb begin
        int            j;
        logic [IW-1:0] cand;
        any  = 1'b0;
        idx  = '0;
        j    = 0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            j    = (int'(ptr) + k) % N;
            cand = IW'(j);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/conv_arbiter.sv
// -----------------------------------------------------------------------------
// conv_arbiter
//   Round-robin arbiter sharing one ConvOperator between NREQ front-ends.
//   One transaction at a time: grant, issue operands, wait for the result,
//   return it to the owning requester, then re-arbitrate.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     req_kernel/req_data        per-requester operand vectors
//     req_valid / req_ready      request handshake (req_ready one-hot or zero)
//     resp_result                result for the current owner
//     resp_valid / resp_ready    one-hot response handshake
//     op_kernel/op_data          operands held for the operator
//     op_in_valid / op_in_ready  operator input handshake
//     op_result                  operator result
//     op_out_valid/op_out_ready  operator output handshake
//     busy                       a transaction is in flight
// -----------------------------------------------------------------------------
module conv_arbiter
    import conv_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  data_vector [NREQ-1:0] req_kernel,
    input  data_vector [NREQ-1:0] req_data,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    output result_t               resp_result,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output data_vector            op_kernel,
    output data_vector            op_data,
    output logic                  op_in_valid,
    input  logic                  op_in_ready,
    input  result_t               op_result,
    input  logic                  op_out_valid,
    output logic                  op_out_ready,
    output logic                  busy
);

    localparam int IW = $clog2(NREQ);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] owner_q;
    data_vector    kernel_q;
    data_vector    data_q;
    result_t       result_q;

    logic          pick_any;
    logic [IW-1:0] pick_idx;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Handshake outputs are forced low while rst is held so nothing is
    // accepted or reported during the reset cycle itself.
    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        resp_valid   = '0;
        op_in_valid  = 1'b0;
        op_out_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        req_ready[pick_idx] = 1'b1;
                        state_d             = ISSUE;
                    end
                end
                ISSUE: begin
                    op_in_valid = 1'b1;
                    if (op_in_ready) state_d = WAIT;
                end
                WAIT: begin
                    op_out_ready = 1'b1;
                    if (op_out_valid) state_d = RESP;
                end
                RESP: begin
                    resp_valid[owner_q] = 1'b1;
                    if (resp_ready[owner_q]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NREQ - 1);
            owner_q  <= '0;
            kernel_q <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            // Operands only change on an acceptance, so they stay stable
            // for the whole transaction.
            if (state_q == IDLE && pick_any) begin
                owner_q  <= pick_idx;
                kernel_q <= req_kernel[pick_idx];
                data_q   <= req_data[pick_idx];
            end
            if (state_q == WAIT && op_out_valid) begin
                result_q <= op_result;
            end
            // Rotation restarts after the owner once its response is taken.
            if (state_q == RESP && resp_ready[owner_q]) begin
                ptr_q <= owner_q;
            end
        end
    end

    assign op_kernel   = kernel_q;
    assign op_data     = data_q;
    assign resp_result = result_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_conv_arbiter.sv
`timescale 1ns/1ps
module tb_conv_arbiter;
    import conv_arbiter_pkg::*;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    data_vector [NREQ-1:0] req_kernel;
    data_vector [NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    result_t               resp_result;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    data_vector            op_kernel;
    data_vector            op_data;
    logic                  op_in_valid;
    logic                  op_in_ready = 1'b0;
    result_t               op_result = '0;
    logic                  op_out_valid = 1'b0;
    logic                  op_out_ready;
    logic                  busy;

    conv_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_kernel   (req_kernel),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .resp_result  (resp_result),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .op_kernel    (op_kernel),
        .op_data      (op_data),
        .op_in_valid  (op_in_valid),
        .op_in_ready  (op_in_ready),
        .op_result    (op_result),
        .op_out_valid (op_out_valid),
        .op_out_ready (op_out_ready),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic result_t dot(input data_vector k, input data_vector d);
        result_t s;
        s = '0;
        for (int j = 0; j < LEN; j++) s += result_t'(k[j]) * result_t'(d[j]);
        return s;
    endfunction

    // First requester after 'last' in circular order.
    function automatic int rr_ref(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        int              idx;
        result_t         val;
        logic [NREQ-1:0] vec;
    } ev_t;

    ev_t grant_q[$];
    ev_t resp_q[$];

    // ---------------- operator model (same reset as the arbiter) ----------
    bit      op_slow  = 1'b0;
    bit      opr_busy = 1'b0;
    int      opr_cnt  = 0;
    result_t opr_res  = '0;

    always begin : operator
        bit      in_hs, out_hs, rs;
        result_t r;
        @(negedge clk);
        rs     = rst;
        in_hs  = op_in_valid && op_in_ready;
        out_hs = op_out_valid && op_out_ready;
        r      = dot(op_kernel, op_data);
        @(posedge clk);
        #1;
        if (rs) begin
            opr_busy     = 1'b0;
            op_out_valid = 1'b0;
            op_result    = '0;
        end else begin
            if (out_hs) begin
                op_out_valid = 1'b0;
                opr_busy     = 1'b0;
            end
            if (in_hs) begin
                opr_busy = 1'b1;
                opr_cnt  = op_slow ? 30 : int'($urandom_range(0, 3));
                opr_res  = r;
            end
            if (opr_busy && !op_out_valid) begin
                if (opr_cnt == 0) begin
                    op_out_valid = 1'b1;
                    op_result    = opr_res;
                end else begin
                    opr_cnt--;
                end
            end
        end
        op_in_ready = !opr_busy && ($urandom_range(0, 3) != 0);
    end

    // ---------------- transaction-level reference model + compare --------
    bit         m_out    = 1'b0;
    bit         m_issued = 1'b0;
    bit         m_got    = 1'b0;
    int         m_owner  = 0;
    int         m_last   = NREQ - 1;
    data_vector m_k      = '0;
    data_vector m_d      = '0;
    result_t    m_res    = '0;

    always @(negedge clk) begin : model
        logic [NREQ-1:0] exp_rr;
        logic [NREQ-1:0] exp_rv;
        int              sel;
        if (rst) begin
            chk("rst req_ready", req_ready, '0);
            chk("rst resp_valid", resp_valid, '0);
            chk("rst op_in_valid", op_in_valid, 1'b0);
            chk("rst op_out_ready", op_out_ready, 1'b0);
            m_out    = 1'b0;
            m_issued = 1'b0;
            m_got    = 1'b0;
            m_owner  = 0;
            m_last   = NREQ - 1;
        end else begin
            exp_rr = '0;
            sel    = -1;
            if (!m_out && req_valid != '0) begin
                sel         = rr_ref(m_last, req_valid);
                exp_rr[sel] = 1'b1;
            end
            exp_rv = '0;
            if (m_out && m_got) exp_rv[m_owner] = 1'b1;
            chk("req_ready", req_ready, exp_rr);
            chk("busy", busy, m_out);
            chk("op_in_valid", op_in_valid, m_out && !m_issued);
            chk("op_out_ready", op_out_ready, m_out && m_issued && !m_got);
            chk("resp_valid", resp_valid, exp_rv);
            if (m_out) begin
                chk("op_kernel", op_kernel, m_k);
                chk("op_data", op_data, m_d);
            end
            if (exp_rv != '0) chk("resp_result", resp_result, m_res);

            if (sel >= 0) begin
                m_out    = 1'b1;
                m_issued = 1'b0;
                m_got    = 1'b0;
                m_owner  = sel;
                m_k      = req_kernel[sel];
                m_d      = req_data[sel];
                m_res    = dot(m_k, m_d);
                grant_q.push_back('{sel, m_res, req_ready});
            end else if (m_out) begin
                if (!m_issued) begin
                    if (op_in_ready) m_issued = 1'b1;
                end else if (!m_got) begin
                    if (op_out_valid) m_got = 1'b1;
                end else if (resp_ready[m_owner]) begin
                    resp_q.push_back('{m_owner, resp_result, resp_valid});
                    m_out  = 1'b0;
                    m_last = m_owner;
                end
            end
        end
    end

    // ---------------- stimulus -------------------------------------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        nxt();
        rst = 1'b0;
        grant_q.delete();
        resp_q.delete();
    endtask

    task automatic wait_grants(input int n, input string nm);
        int c;
        c = 0;
        while (grant_q.size() < n && c < 400) begin
            nxt();
            c++;
        end
        chk({nm, " grants reached"}, grant_q.size() >= n, 1'b1);
    endtask

    task automatic wait_resps(input int n, input string nm);
        int c;
        c = 0;
        while (resp_q.size() < n && c < 400) begin
            nxt();
            c++;
        end
        chk({nm, " responses reached"}, resp_q.size() >= n, 1'b1);
    endtask

    task automatic wait_resp_valid(input string nm);
        int c;
        c = 0;
        while (resp_valid == '0 && c < 400) begin
            nxt();
            c++;
        end
        chk({nm, " resp_valid seen"}, resp_valid != '0, 1'b1);
    endtask

    task automatic rand_vec(input int r);
        for (int j = 0; j < LEN; j++) begin
            req_kernel[r][j] = elem_t'($urandom);
            req_data[r][j]   = elem_t'($urandom);
        end
    endtask

    initial begin : stim
        int      c;
        result_t held;
        int      exp_order[5];
        exp_order = '{0, 1, 2, 0, 1};

        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_kernel = '0;
        req_data   = '0;
        repeat (3) nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset op_kernel", op_kernel, '0);
        chk("reset resp_result", resp_result, '0);
        nxt();

        // Basic transaction
        do_reset();
        resp_ready = '1;
        for (int j = 0; j < LEN; j++) begin
            req_kernel[0][j] = elem_t'(j + 1);
            req_data[0][j]   = elem_t'(j + 5);
        end
        req_valid = 4'b0001;
        wait_grants(1, "basic");
        req_valid = '0;
        wait_resps(1, "basic");
        if (resp_q.size() >= 1 && grant_q.size() >= 1) begin
            chk("basic model dot", grant_q[0].val, 70);
            chk("basic resp_valid", resp_q[0].vec, 4'b0001);
            chk("basic result", resp_q[0].val, 70);
        end

        // Round-robin among three held requesters
        do_reset();
        for (int r = 0; r < NREQ; r++) rand_vec(r);
        resp_ready = '1;
        req_valid  = 4'b0111;
        wait_grants(5, "rr");
        req_valid = '0;
        wait_resps(5, "rr");
        if (grant_q.size() >= 5)
            for (int i = 0; i < 5; i++) chk($sformatf("rr order %0d", i), grant_q[i].idx, exp_order[i]);

        // Response backpressure
        do_reset();
        rand_vec(1);
        resp_ready = '0;
        req_valid  = 4'b0010;
        wait_grants(1, "bp");
        req_valid = '1;
        wait_resp_valid("bp");
        held = (grant_q.size() >= 1) ? grant_q[0].val : '0;
        repeat (10) begin
            @(negedge clk);
            chk("bp resp_valid", resp_valid, 4'b0010);
            chk("bp resp_result", resp_result, held);
            chk("bp req_ready", req_ready, '0);
            chk("bp op_in_valid", op_in_valid, 1'b0);
        end
        nxt();
        resp_ready = '1;
        wait_grants(2, "bp");
        req_valid = '0;
        if (grant_q.size() >= 2) chk("bp resume grant", grant_q[1].idx, 2);
        wait_resps(2, "bp");

        // Ready from non-owners is ignored
        do_reset();
        rand_vec(2);
        resp_ready = 4'b1011;
        req_valid  = 4'b0100;
        wait_grants(1, "wo");
        req_valid = '0;
        wait_resp_valid("wo");
        repeat (6) begin
            @(negedge clk);
            chk("wo resp_valid", resp_valid, 4'b0100);
            chk("wo busy", busy, 1'b1);
        end
        nxt();
        resp_ready = 4'b0100;
        wait_resps(1, "wo");
        if (resp_q.size() >= 1) chk("wo owner", resp_q[0].idx, 2);
        @(negedge clk);
        chk("wo idle after", busy, 1'b0);
        nxt();

        // Reset while waiting for the operator
        do_reset();
        op_slow = 1'b1;
        rand_vec(0);
        resp_ready = '1;
        req_valid  = 4'b0001;
        wait_grants(1, "rw");
        req_valid = '0;
        c = 0;
        while (!op_out_ready && c < 100) begin
            nxt();
            c++;
        end
        chk("rw reached wait", op_out_ready, 1'b1);
        rst = 1'b1;
        nxt();
        rst     = 1'b0;
        op_slow = 1'b0;
        @(negedge clk);
        chk("rw req_ready", req_ready, '0);
        chk("rw resp_valid", resp_valid, '0);
        chk("rw op_in_valid", op_in_valid, 1'b0);
        chk("rw op_out_ready", op_out_ready, 1'b0);
        chk("rw busy", busy, 1'b0);
        chk("rw op_kernel", op_kernel, '0);
        chk("rw op_data", op_data, '0);
        chk("rw resp_result", resp_result, '0);
        grant_q.delete();
        resp_q.delete();
        repeat (20) nxt();
        chk("rw no stale response", resp_q.size(), 0);
        for (int j = 0; j < LEN; j++) begin
            req_kernel[0][j] = elem_t'(-1);
            req_data[0][j]   = elem_t'(2);
        end
        req_valid = 4'b0001;
        wait_grants(1, "rw2");
        req_valid = '0;
        wait_resps(1, "rw2");
        if (resp_q.size() >= 1) chk("rw signed result", resp_q[0].val, -8);

        // Single requester streaming
        do_reset();
        req_valid = 4'b1000;
        c = 0;
        while (resp_q.size() < 5 && c < 1000) begin
            rand_vec(3);
            resp_ready = NREQ'($urandom);
            if (grant_q.size() >= 5) req_valid = '0;
            nxt();
            c++;
        end
        req_valid = '0;
        chk("stream responses", resp_q.size(), 5);
        chk("stream grants", grant_q.size(), 5);
        if (resp_q.size() >= 5 && grant_q.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("stream grant %0d", i), grant_q[i].idx, 3);
                chk($sformatf("stream order %0d", i), resp_q[i].val, grant_q[i].val);
            end

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NREQ; r++) rand_vec(r);
            req_valid  = NREQ'($urandom);
            resp_ready = NREQ'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            nxt();
        end
        rst       = 1'b0;
        req_valid = '0;
        repeat (5) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
